serial_fa_mult_ctrl: RTL and testbench

Sequencer that time-shares a single full-adder cell to compute an unsigned N×N product by bit-serial shift-and-add. It replaces the combinational array multiplier where area matters. It owns the operand registers, the accumulator shift register, the carry flip-flop and all counters. The FA cell is instantiated inside the block as its only arithmetic resource.

---
 rtl/serial_fa_mult_ctrl.sv | 168 ++++++++++++++++
 tb/tb_serial_fa_mult_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_fa_mult_ctrl.sv
// Bit-serial shift-and-add multiplier built around one full-adder cell.
// Each partial product rb[p]*ra is added into a rotating 2N-bit accumulator
// one bit per cycle. Every pass takes 2N cycles, so latency is fixed at 2N*N cycles.

module serial_fa_mult_fa (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ cin;
    assign co = (x & y) | (cin & (x ^ y));
endmodule

module serial_fa_mult_ctrl #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);
    localparam int PW = $clog2(N);
    localparam int KW = $clog2(2 * N);

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    ra_q, ra_d;
    logic [N-1:0]    rb_q, rb_d;
    logic [2*N-1:0]  acc_q, acc_d;
    logic            carry_q, carry_d;
    logic [PW-1:0]   p_q, p_d;
    logic [KW-1:0]   k_q, k_d;
    logic [2*N-1:0]  product_q, product_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            last_bit, last_pass;
    logic [KW-1:0]   kmp;
    logic            in_win;
    logic [N-1:0]    ra_sh, rb_sh;
    logic            fa_x, fa_y, fa_cin, fa_s, fa_co;

    assign last_bit  = (k_q == KW'(2 * N - 1));
    assign last_pass = (p_q == PW'(N - 1));

    // Partial-product bit selection: ra[k-p] is only in range while p <= k < p+N
    always_comb begin
        kmp    = k_q - KW'(p_q);
        in_win = (k_q >= KW'(p_q)) && (kmp < KW'(N));
        ra_sh  = ra_q >> kmp;
        rb_sh  = rb_q >> p_q;
        fa_x   = acc_q[0];
        fa_y   = in_win & ra_sh[0] & rb_sh[0];
        fa_cin = (k_q != '0) & carry_q;
    end

    serial_fa_mult_fa u_fa (
        .x   (fa_x),
        .y   (fa_y),
        .cin (fa_cin),
        .s   (fa_s),
        .co  (fa_co)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ADD;
            S_ADD:   if (last_bit && last_pass) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state so busy/done come straight out of flops
    always_comb begin
        busy_d = (state_d == S_ADD);
        done_d = (state_d == S_DONE);
    end

    // Datapath next-values: operand latch, accumulator rotation, counters, result
    always_comb begin
        ra_d      = ra_q;
        rb_d      = rb_q;
        acc_d     = acc_q;
        carry_d   = carry_q;
        p_d       = p_q;
        k_d       = k_q;
        product_d = product_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ra_d    = a;
                    rb_d    = b;
                    acc_d   = '0;
                    carry_d = 1'b0;
                    p_d     = '0;
                    k_d     = '0;
                end
            end
            S_ADD: begin
                acc_d = {fa_s, acc_q[2*N-1:1]};
                if (last_bit) begin
                    // Top carry of a pass is always zero; drop it so the next pass starts clean
                    carry_d = 1'b0;
                    k_d     = '0;
                    if (last_pass) begin
                        p_d       = '0;
                        product_d = {fa_s, acc_q[2*N-1:1]};
                    end else begin
                        p_d = p_q + PW'(1);
                    end
                end else begin
                    carry_d = fa_co;
                    k_d     = k_q + KW'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ra_q      <= '0;
            rb_q      <= '0;
            acc_q     <= '0;
            carry_q   <= 1'b0;
            p_q       <= '0;
            k_q       <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            acc_q     <= acc_d;
            carry_q   <= carry_d;
            p_q       <= p_d;
            k_q       <= k_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_serial_fa_mult_ctrl.sv
// Directed bench for serial_fa_mult_ctrl with N=4.
// Cycle c of an operation is observed on the falling edge just before rising edge c,
// where rising edge 0 is the one that samples start.

module tb_serial_fa_mult_ctrl;
    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int total;
    int bad;

    serial_fa_mult_ctrl #(.N(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one start pulse and observe cycles 1..40 (no comparisons here)
    task automatic run_op(input logic [3:0] ai, input logic [3:0] bi, input int chg,
                          output int done_cyc, output int done_cnt, output int busy_cnt,
                          output int busy_first, output int busy_last, output logic busy_at_done,
                          output logic [7:0] prod_done, output logic [7:0] prod_after);
        done_cyc = 0; done_cnt = 0; busy_cnt = 0; busy_first = 0; busy_last = 0;
        busy_at_done = 1'bx; prod_done = 'x; prod_after = 'x;
        @(negedge clk);
        a = ai; b = bi; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == chg) begin
                a = 4'd0; b = 4'd0;
            end
            if (busy === 1'b1) begin
                busy_cnt++;
                if (busy_first == 0) busy_first = c;
                busy_last = c;
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc == 0) begin
                    done_cyc     = c;
                    prod_done    = product;
                    busy_at_done = busy;
                end
            end
            if (c == 40) prod_after = product;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done); end
        total++;
        if (product !== 8'd0) begin bad++; $display("FAIL reset_product got=%0d want=0", product); end
        rst = 1'b0;
    endtask

    task automatic test_max();
        int dc, dn, bc, bf, bl; logic bd; logic [7:0] pd, pa;
        run_op(4'd15, 4'd15, 0, dc, dn, bc, bf, bl, bd, pd, pa);
        total++;
        if (bf != 1 || bl != 32 || bc != 32) begin
            bad++; $display("FAIL max_busy first=%0d last=%0d cnt=%0d want 1/32/32", bf, bl, bc);
        end
        total++;
        if (dc != 33 || dn != 1) begin bad++; $display("FAIL max_done_cycle got=%0d cnt=%0d want=33 cnt=1", dc, dn); end
        total++;
        if (pd !== 8'hE1) begin bad++; $display("FAIL max_product got=%0h want=e1", pd); end
        total++;
        if (bd !== 1'b0) begin bad++; $display("FAIL max_busy_at_done got=%0b want=0", bd); end
        total++;
        if (pa !== 8'hE1) begin bad++; $display("FAIL max_product_hold got=%0h want=e1", pa); end
    endtask

    task automatic test_latency();
        int dc, dn, bc, bf, bl; logic bd; logic [7:0] pd, pa;
        run_op(4'd0, 4'd9, 0, dc, dn, bc, bf, bl, bd, pd, pa);
        total++;
        if (dc != 33) begin bad++; $display("FAIL lat_0x9_cycle got=%0d want=33", dc); end
        total++;
        if (pd !== 8'd0) begin bad++; $display("FAIL lat_0x9_product got=%0d want=0", pd); end
        run_op(4'd9, 4'd0, 0, dc, dn, bc, bf, bl, bd, pd, pa);
        total++;
        if (dc != 33) begin bad++; $display("FAIL lat_9x0_cycle got=%0d want=33", dc); end
        total++;
        if (pd !== 8'd0) begin bad++; $display("FAIL lat_9x0_product got=%0d want=0", pd); end
    endtask

    task automatic test_midchange();
        int dc, dn, bc, bf, bl; logic bd; logic [7:0] pd, pa;
        run_op(4'd13, 4'd11, 5, dc, dn, bc, bf, bl, bd, pd, pa);
        total++;
        if (dc != 33) begin bad++; $display("FAIL mid_cycle got=%0d want=33", dc); end
        total++;
        if (pd !== 8'h8F) begin bad++; $display("FAIL mid_product got=%0d want=143", pd); end
        // A few more pairs exercising different bit patterns
        run_op(4'd5, 4'd10, 0, dc, dn, bc, bf, bl, bd, pd, pa);
        total++;
        if (pd !== 8'd50) begin bad++; $display("FAIL mix_5x10 got=%0d want=50", pd); end
        run_op(4'd8, 4'd12, 0, dc, dn, bc, bf, bl, bd, pd, pa);
        total++;
        if (pd !== 8'd96) begin bad++; $display("FAIL mix_8x12 got=%0d want=96", pd); end
    endtask

    task automatic test_start_held();
        int d1, d2, d3, dn; logic [7:0] p1; logic busy10;
        d1 = 0; d2 = 0; d3 = 0; dn = 0; p1 = 'x; busy10 = 1'bx;
        @(negedge clk);
        a = 4'd3; b = 4'd5; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 105; c++) begin
            @(negedge clk);
            if (c == 10) busy10 = busy;
            if (c == 70) start = 1'b0;
            if (done === 1'b1) begin
                dn++;
                if (dn == 1) begin d1 = c; p1 = product; end
                else if (dn == 2) d2 = c;
                else if (dn == 3) d3 = c;
            end
        end
        total++;
        if (busy10 !== 1'b1) begin bad++; $display("FAIL held_busy_c10 got=%0b want=1", busy10); end
        total++;
        if (d1 != 33 || p1 !== 8'd15) begin bad++; $display("FAIL held_first got cyc=%0d prod=%0d want cyc=33 prod=15", d1, p1); end
        total++;
        if (d2 != 67) begin bad++; $display("FAIL held_second_cycle got=%0d want=67", d2); end
        total++;
        if (d3 != 101 || dn != 3) begin bad++; $display("FAIL held_third got cyc=%0d cnt=%0d want cyc=101 cnt=3", d3, dn); end
    endtask

    task automatic test_reset_mid();
        int dc, dn, bc, bf, bl; logic [7:0] pd, pa; logic bd;
        int stray;
        stray = 0;
        @(negedge clk);
        a = 4'd7; b = 4'd6; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (c == 10) rst = 1'b1;
            if (c == 11) begin
                rst = 1'b0;
                total++;
                if (busy !== 1'b0 || done !== 1'b0 || product !== 8'd0) begin
                    bad++; $display("FAIL rstmid_c11 busy=%0b done=%0b prod=%0d want 0/0/0", busy, done, product);
                end
            end
            if (c > 11 && (busy !== 1'b0 || done !== 1'b0)) stray++;
        end
        total++;
        if (stray != 0) begin bad++; $display("FAIL rstmid_idle stray_cycles=%0d want=0", stray); end
        run_op(4'd7, 4'd6, 0, dc, dn, bc, bf, bl, bd, pd, pa);
        total++;
        if (dc != 33 || pd !== 8'd42) begin bad++; $display("FAIL rstmid_restart cyc=%0d prod=%0d want cyc=33 prod=42", dc, pd); end
    endtask

    task automatic test_reset_done();
        int dc, dn, bc, bf, bl; logic [7:0] pd, pa; logic bd;
        @(negedge clk);
        a = 4'd1; b = 4'd1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            if (c == 33) begin
                total++;
                if (done !== 1'b1 || product !== 8'd1) begin
                    bad++; $display("FAIL rstdone_c33 done=%0b prod=%0d want 1/1", done, product);
                end
                rst = 1'b1;
            end
            if (c == 34) begin
                rst = 1'b0;
                total++;
                if (product !== 8'd0 || done !== 1'b0 || busy !== 1'b0) begin
                    bad++; $display("FAIL rstdone_c34 prod=%0d done=%0b busy=%0b want 0/0/0", product, done, busy);
                end
            end
        end
        run_op(4'd2, 4'd3, 0, dc, dn, bc, bf, bl, bd, pd, pa);
        total++;
        if (dc != 33 || pd !== 8'd6) begin bad++; $display("FAIL rstdone_next cyc=%0d prod=%0d want cyc=33 prod=6", dc, pd); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_max();
        test_latency();
        test_midchange();
        test_start_held();
        test_reset_mid();
        test_reset_done();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
